// File: rtl/ntt_addr_gen.sv
// Address, twiddle-index and write-back sequencer for an in-place radix-2 NTT/INTT.
// Inverse schedule is compiled in only when NTT_ADDR_GEN_INTT_EN is defined.
module ntt_addr_gen #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BF_LAT     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic                  en_a,
  output logic                  en_b,
  output logic                  we_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [ADDR_WIDTH-1:0] waddr_a,
  output logic [ADDR_WIDTH-1:0] waddr_b,
  output logic                  bf_valid,
  output logic [6:0]            zeta_idx
);

  localparam int CW = ADDR_WIDTH - 1;
  localparam int SW = $clog2(ADDR_WIDTH);
  localparam int DW = $clog2(BF_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] C_LAST = '1;
  localparam logic [SW-1:0] S_MIN  = SW'(1);
  localparam logic [SW-1:0] S_MAX  = SW'(CW);

  logic [1:0]            r_state;
  logic [CW-1:0]         r_c;
  logic [SW-1:0]         r_s;
  logic                  r_inv;
  logic [DW-1:0]         r_dcnt;
  logic [ADDR_WIDTH-1:0] r_ra_hold;
  logic [ADDR_WIDTH-1:0] r_rb_hold;
  logic [BF_LAT-1:0]     r_pv;
  logic [ADDR_WIDTH-1:0] r_pa [BF_LAT];
  logic [ADDR_WIDTH-1:0] r_pb [BF_LAT];
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wa;
  logic [ADDR_WIDTH-1:0] r_wb;
  logic [6:0]            r_zeta;

  logic                  w_issue;
  logic                  w_mode_inv;
  logic                  w_last_layer;
  logic [ADDR_WIDTH-1:0] w_len;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic [ADDR_WIDTH-1:0] w_cext;
  logic [ADDR_WIDTH-1:0] w_grp;
  logic [ADDR_WIDTH-1:0] w_ra;
  logic [ADDR_WIDTH-1:0] w_rb;
  logic [ADDR_WIDTH-1:0] w_zfull;

`ifdef NTT_ADDR_GEN_INTT_EN
  assign w_mode_inv = mode;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
  assign w_mode_inv    = 1'b0;
`endif

  // Butterfly pair: insert a zero at bit s of the counter; the partner sits len above.
  assign w_issue = (r_state == S_ISSUE);
  assign w_len   = ADDR_WIDTH'(1) << r_s;
  assign w_mask  = w_len - ADDR_WIDTH'(1);
  assign w_cext  = ADDR_WIDTH'(r_c);
  assign w_grp   = w_cext >> r_s;
  assign w_ra    = ((w_cext & ~w_mask) << 1) | (w_cext & w_mask);
  assign w_rb    = w_ra | w_len;
  assign w_zfull = r_inv ? ((ADDR_WIDTH'(1) << (ADDR_WIDTH - int'(r_s))) - ADDR_WIDTH'(1) - w_grp)
                         : ((ADDR_WIDTH'(1) << (CW - int'(r_s))) + w_grp);
  assign w_last_layer = r_inv ? (r_s == S_MAX) : (r_s == S_MIN);

  assign busy     = w_issue | (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign en_a     = w_issue | r_we;
  assign en_b     = w_issue | r_we;
  assign we_a     = r_we;
  assign we_b     = r_we;
  assign raddr_a  = w_issue ? w_ra : r_ra_hold;
  assign raddr_b  = w_issue ? w_rb : r_rb_hold;
  assign waddr_a  = r_wa;
  assign waddr_b  = r_wb;
  assign bf_valid = r_pv[0];
  assign zeta_idx = r_zeta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_s     <= '0;
      r_inv   <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ISSUE;
            r_c     <= '0;
            r_inv   <= w_mode_inv;
            r_s     <= w_mode_inv ? S_MIN : S_MAX;
          end
        end
        S_ISSUE: begin
          r_c <= r_c + 1'b1;
          if (r_c == C_LAST) begin
            r_state <= S_DRAIN;
            r_dcnt  <= '0;
          end
        end
        S_DRAIN: begin
          // Hold off the next layer until the last write-back of this one has landed.
          if (r_dcnt == DW'(BF_LAT)) begin
            if (w_last_layer) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
              r_s     <= r_inv ? r_s + 1'b1 : r_s - 1'b1;
            end
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write-back delay line: valid bits reset, addresses ride along unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv      <= '0;
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_wb      <= '0;
      r_ra_hold <= '0;
      r_rb_hold <= '0;
      r_zeta    <= '0;
    end else begin
      r_pv[0] <= w_issue;
      for (int k = 1; k < BF_LAT; k++) r_pv[k] <= r_pv[k-1];
      r_we <= r_pv[BF_LAT-1];
      if (r_pv[BF_LAT-1]) begin
        r_wa <= r_pa[BF_LAT-1];
        r_wb <= r_pb[BF_LAT-1];
      end
      if (w_issue) begin
        r_ra_hold <= w_ra;
        r_rb_hold <= w_rb;
        r_zeta    <= w_zfull[6:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_pa[0] <= w_ra;
    r_pb[0] <= w_rb;
    for (int k = 1; k < BF_LAT; k++) begin
      r_pa[k] <= r_pa[k-1];
      r_pb[k] <= r_pb[k-1];
    end
  end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Bench for ntt_addr_gen: cycle-by-cycle comparison against a layer/butterfly schedule model,
// directed vector table, reset-abort sequence and randomized start/mode noise.
module tb_ntt_addr_gen;

  localparam int AW    = 8;
  localparam int BL    = 4;
  localparam int PER   = 129 + BL;
  localparam int NBUSY = 7 * PER;
  localparam int ET    = NBUSY + 9;

  logic          clk = 1'b0;
  logic          rst_n, start, mode;
  logic          busy, done, en_a, en_b, we_a, we_b, bf_valid;
  logic [AW-1:0] raddr_a, raddr_b, waddr_a, waddr_b;
  logic [6:0]    zeta_idx;

  always #5 clk = ~clk;

  ntt_addr_gen #(.DEPTH(256), .ADDR_WIDTH(AW), .BF_LAT(BL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .waddr_a(waddr_a), .waddr_b(waddr_b),
    .bf_valid(bf_valid), .zeta_idx(zeta_idx)
  );

  int checks   = 0;
  int failures = 0;

  // Reference schedule, indexed by cycle after the accepted start.
  int e_is [0:ET], e_ra [0:ET], e_rb [0:ET], e_bf [0:ET], e_z [0:ET];
  int e_we [0:ET], e_wa [0:ET], e_wb [0:ET], e_busy [0:ET], e_done [0:ET];
  int c_ra = 0, c_rb = 0, c_wa = 0, c_wb = 0, c_z = 0;
  int o_en [0:ET], o_ra [0:ET], o_rb [0:ET], o_bf [0:ET], o_z [0:ET];
  int o_we [0:ET], o_wa [0:ET], o_wb [0:ET];

  typedef struct {
    bit m;
    int t;
    int kind;   // 0 read pair, 1 butterfly/zeta, 2 write pair
    int a;
    int b;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void build_model(input bit inv);
    int t, s, len, g, ra, z, p;
    for (int i = 0; i <= ET; i++) begin
      e_is[i] = 0; e_bf[i] = 0; e_we[i] = 0;
      e_ra[i] = 0; e_rb[i] = 0; e_z[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
      e_busy[i] = (i >= 1 && i <= NBUSY) ? 1 : 0;
      e_done[i] = (i == NBUSY + 1) ? 1 : 0;
    end
    for (int l = 0; l < 7; l++) begin
      s   = inv ? l + 1 : 7 - l;
      len = 1 << s;
      for (int c = 0; c < 128; c++) begin
        t  = 1 + l * PER + c;
        g  = c / len;
        ra = g * 2 * len + c % len;
        z  = inv ? (1 << (8 - s)) - 1 - g : (1 << (7 - s)) + g;
        e_is[t] = 1; e_ra[t] = ra; e_rb[t] = ra + len;
        e_bf[t+1] = 1; e_z[t+1] = z;
        e_we[t+1+BL] = 1; e_wa[t+1+BL] = ra; e_wb[t+1+BL] = ra + len;
      end
    end
    e_ra[0] = c_ra; e_rb[0] = c_rb; e_z[0] = c_z; e_wa[0] = c_wa; e_wb[0] = c_wb;
    for (int i = 1; i <= ET; i++) begin
      p = i - 1;
      if (e_is[i] == 0) begin e_ra[i] = e_ra[p]; e_rb[i] = e_rb[p]; end
      if (e_bf[i] == 0) e_z[i] = e_z[p];
      if (e_we[i] == 0) begin e_wa[i] = e_wa[p]; e_wb[i] = e_wb[p]; end
    end
  endfunction

  function automatic logic [63:0] act_vec();
    return 64'({busy, done, en_a, en_b, we_a, we_b, bf_valid,
                raddr_a, raddr_b, waddr_a, waddr_b, zeta_idx});
  endfunction

  function automatic logic [63:0] exp_vec(input int t);
    logic en;
    en = (e_is[t] != 0) || (e_we[t] != 0);
    return 64'({1'(e_busy[t]), 1'(e_done[t]), en, en, 1'(e_we[t]), 1'(e_we[t]), 1'(e_bf[t]),
                8'(e_ra[t]), 8'(e_rb[t]), 8'(e_wa[t]), 8'(e_wb[t]), 7'(e_z[t])});
  endfunction

  // Entered just after a rising edge (cycle 0); returns in the same phase.
  task automatic run_xfer(input bit m, input bit noise, input int abort_t);
    int busy_n = 0, done_n = 0, wa_n = 0, wb_n = 0, hz = 0, nw = 0;
    int pra = 0, prb = 0;
    bit pend [256];
    bit eff;
`ifdef NTT_ADDR_GEN_INTT_EN
    eff = m;
`else
    eff = 1'b0;
`endif
    build_model(eff);
    for (int i = 0; i < 256; i++) pend[i] = 1'b0;
    start = 1'b1;
    mode  = m;
    for (int t = 1; t <= ET; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (noise && t <= NBUSY + 1 && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        mode  = 1'($urandom);
      end
      @(negedge clk);
      chk($sformatf("trace m=%0d t=%0d", m, t), act_vec(), exp_vec(t));
      o_en[t] = int'(en_a & en_b); o_ra[t] = int'(raddr_a); o_rb[t] = int'(raddr_b);
      o_bf[t] = int'(bf_valid);    o_z[t]  = int'(zeta_idx);
      o_we[t] = int'(we_a & we_b); o_wa[t] = int'(waddr_a); o_wb[t] = int'(waddr_b);
      if (busy) busy_n++;
      if (done) done_n++;
      if (we_a) wa_n++;
      if (we_b) wb_n++;
      if (bf_valid) begin
        if (pend[pra] || pend[prb]) hz++;
        pend[pra] = 1'b1;
        pend[prb] = 1'b1;
      end
      if (we_a) pend[waddr_a] = 1'b0;
      if (we_b) pend[waddr_b] = 1'b0;
      pra = int'(raddr_a);
      prb = int'(raddr_b);
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero", act_vec(), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (we_a || we_b || en_a || en_b || busy || bf_valid || done) nw++;
        end
        chk("abort_no_activity_after_release", 64'(nw), 64'd0);
        c_ra = 0; c_rb = 0; c_wa = 0; c_wb = 0; c_z = 0;
        @(posedge clk); #1;
        return;
      end
    end
    chk($sformatf("busy_cycles m=%0d", m), 64'(busy_n), 64'(NBUSY));
    chk($sformatf("done_pulses m=%0d", m), 64'(done_n), 64'd1);
    chk($sformatf("writes_a m=%0d", m), 64'(wa_n), 64'd896);
    chk($sformatf("writes_b m=%0d", m), 64'(wb_n), 64'd896);
    chk($sformatf("raw_hazards m=%0d", m), 64'(hz), 64'd0);
    c_ra = e_ra[ET]; c_rb = e_rb[ET]; c_wa = e_wa[ET]; c_wb = e_wb[ET]; c_z = e_z[ET];
    @(posedge clk); #1;
  endtask

  task automatic check_table(input bit m);
    int t;
    foreach (tbl[i]) begin
      if (tbl[i].m == m) begin
        t = tbl[i].t;
        case (tbl[i].kind)
          0: chk($sformatf("vec_read m=%0d t=%0d", m, t),
                 64'((o_en[t] << 16) | (o_ra[t] << 8) | o_rb[t]),
                 64'((1 << 16) | (tbl[i].a << 8) | tbl[i].b));
          1: chk($sformatf("vec_zeta m=%0d t=%0d", m, t),
                 64'((o_bf[t] << 8) | o_z[t]), 64'((1 << 8) | tbl[i].a));
          default: chk($sformatf("vec_write m=%0d t=%0d", m, t),
                 64'((o_we[t] << 16) | (o_wa[t] << 8) | o_wb[t]),
                 64'((1 << 16) | (tbl[i].a << 8) | tbl[i].b));
        endcase
      end
    end
  endtask

  initial begin
    tbl.push_back('{0, 1, 0, 0, 128});
    tbl.push_back('{0, 2, 1, 1, 0});
    tbl.push_back('{0, 6, 2, 0, 128});
    tbl.push_back('{0, 134, 0, 0, 64});
    tbl.push_back('{0, 135, 1, 2, 0});
    tbl.push_back('{0, 139, 2, 0, 64});
    tbl.push_back('{0, 198, 0, 128, 192});
    tbl.push_back('{0, 199, 1, 3, 0});
`ifdef NTT_ADDR_GEN_INTT_EN
    tbl.push_back('{1, 1, 0, 0, 2});
    tbl.push_back('{1, 2, 1, 127, 0});
    tbl.push_back('{1, 2, 0, 1, 3});
    tbl.push_back('{1, 3, 1, 127, 0});
    tbl.push_back('{1, 3, 0, 4, 6});
    tbl.push_back('{1, 4, 1, 126, 0});
    tbl.push_back('{1, 6, 2, 0, 2});
    tbl.push_back('{1, 799, 0, 0, 128});
    tbl.push_back('{1, 800, 1, 1, 0});
`else
    tbl.push_back('{1, 1, 0, 0, 128});
    tbl.push_back('{1, 2, 1, 1, 0});
    tbl.push_back('{1, 6, 2, 0, 128});
    tbl.push_back('{1, 134, 0, 0, 64});
    tbl.push_back('{1, 135, 1, 2, 0});
    tbl.push_back('{1, 198, 0, 128, 192});
    tbl.push_back('{1, 199, 1, 3, 0});
`endif

    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", act_vec(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", act_vec(), 64'd0);

    run_xfer(1'b0, 1'b0, 0);
    check_table(1'b0);
    run_xfer(1'b1, 1'b0, 0);
    check_table(1'b1);
    run_xfer(1'b0, 1'b0, 1 + 2 * PER + 50);
    run_xfer(1'b0, 1'b0, 0);
    check_table(1'b0);

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 5)) begin
        @(posedge clk); #1;
      end
      run_xfer(1'($urandom), 1'b1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
